// File: rtl/booth_r4_mul_unit_if.sv
// ---------------------------------------------------------------------------------------------
// booth_r4_mul_unit_if
//   Operand/result handshake bundle for the radix-4 Booth multiplier.
//   The master drives operands and accepts results. The slave is the multiplier.
//
// Signals
//   in_valid   master -> slave   operands valid
//   in_ready   slave  -> master  unit can accept operands
//   a          master -> slave   multiplicand, WIDTH bits
//   b          master -> slave   multiplier, WIDTH bits
//   a_signed   master -> slave   1: a is two's complement
//   b_signed   master -> slave   1: b is two's complement
//   out_valid  slave  -> master  p holds a valid result
//   out_ready  master -> slave   consumer accepts result
//   p          slave  -> master  full-width product, 2*WIDTH bits
// ---------------------------------------------------------------------------------------------
interface booth_r4_mul_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 a_signed;
    logic                 b_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output in_valid, a, b, a_signed, b_signed, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/booth_r4_mul_unit.sv
// ---------------------------------------------------------------------------------------------
// booth_r4_mul_unit
//   Multi-cycle radix-4 Booth multiplier. Two multiplier bits are retired per cycle, so an
//   operation takes K = (WIDTH+2)/2 Booth steps. Per-operand signedness covers
//   MUL/MULH/MULHSU/MULHU; the full 2*WIDTH-bit product is returned and the execute stage
//   picks the half it needs. A zero operand skips the iteration entirely.
//
// Ports
//   clk      in     clock
//   rst      in     synchronous, active-high reset; aborts any operation in flight
//   io_bus   slave  operand/result handshake bundle (see booth_r4_mul_unit_if)
// ---------------------------------------------------------------------------------------------
module booth_r4_mul_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_r4_mul_unit_if.slave    io_bus
);

    localparam int unsigned K  = (WIDTH + 2) / 2;
    localparam int unsigned AW = WIDTH + 4;    // accumulator / multiplicand width
    localparam int unsigned QW = WIDTH + 2;    // extended multiplier width
    localparam int unsigned SW = AW + QW + 1;  // {ACC, Q, q_1}
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("booth_r4_mul_unit: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       r_m;
    logic [QW-1:0]       r_q;
    logic                r_q1;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_p;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_zero;
    logic                w_ea;
    logic                w_eb;
    logic [AW-1:0]       w_addend;
    logic                w_neg;
    logic [AW-1:0]       w_sum;
    logic [SW-1:0]       w_shift;
    logic [AW-1:0]       w_acc_next;
    logic [QW-1:0]       w_q_next;
    logic                w_q1_next;
    logic                w_last_step;

    // -----------------------------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------------------------
    // DONE can retire and accept on the same edge, so in_ready looks through out_ready there.
    assign w_in_ready  = (r_state == StIdle) | ((r_state == StDone) & io_bus.out_ready);
    assign w_accept    = io_bus.in_valid & w_in_ready;
    assign w_zero      = (io_bus.a == '0) | (io_bus.b == '0);
    assign w_last_step = (r_state == StBusy) & (r_cnt == '0);

    assign w_ea = io_bus.a_signed & io_bus.a[WIDTH-1];
    assign w_eb = io_bus.b_signed & io_bus.b[WIDTH-1];

    // -----------------------------------------------------------------------------------------
    // Booth recoding of {Q[1], Q[0], q_1}
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_addend = '0;
        w_neg    = 1'b0;
        unique case ({r_q[1:0], r_q1})
            3'b001, 3'b010: begin
                w_addend = r_m;
            end
            3'b011: begin
                w_addend = {r_m[AW-2:0], 1'b0};
            end
            3'b100: begin
                w_addend = {r_m[AW-2:0], 1'b0};
                w_neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                w_addend = r_m;
                w_neg    = 1'b1;
            end
            default: begin
                // 000 / 111: add nothing
            end
        endcase
    end

    // Subtraction folds into the one adder as ~X + 1 via the carry-in term.
    assign w_sum = r_acc + (w_addend ^ {AW{w_neg}}) + {{(AW-1){1'b0}}, w_neg};

    // Arithmetic shift of the whole {ACC, Q, q_1} register by two, same cycle as the add.
    assign w_shift    = $signed({w_sum, r_q, r_q1}) >>> 2;
    assign w_acc_next = w_shift[SW-1:QW+1];
    assign w_q_next   = w_shift[QW:1];
    assign w_q1_next  = w_shift[0];

    // -----------------------------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_zero ? StDone : StBusy;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_next = StIdle;
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        w_state_next = StDone;
                    end
                end
                StDone: begin
                    if (io_bus.out_ready) begin
                        w_state_next = StIdle;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_m   <= {{4{w_ea}}, io_bus.a};
            r_q   <= {{2{w_eb}}, io_bus.b};
            r_q1  <= 1'b0;
            r_cnt <= CW'(K - 1);
            if (w_zero) begin
                r_p <= '0;
            end
        end else if (r_state == StBusy) begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_q1  <= w_q1_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Product is taken from the post-step value so no extra cycle is spent in BUSY.
            if (w_last_step) begin
                r_p <= w_shift[2*WIDTH:1];
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = (r_state == StDone);
    assign io_bus.p         = r_p;

endmodule
